// File: rtl/ab_seq_pkg.sv
// Shared types and helpers for the A/B overlap sequence generator.
package ab_seq_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} ab_state_t;

    // Last phase count of a run: whichever of a or b finishes later.
    function automatic int ab_end(input int a_len, input int b_dly, input int b_len);
        return (a_len > b_dly + b_len) ? a_len : (b_dly + b_len);
    endfunction

endpackage

// File: rtl/ab_seq_gen_rise_det.sv
// Start edge detector: registers start and splits each rise into an accepted
// trigger (idle) or a dropped trigger (busy).
module rise_det #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic busy,
    output logic trig,
    output logic ovr
);

    logic start_q;
    logic rise;

    // Reset value of 1 keeps a start held high across reset from looking like a rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            start_q <= RST_VAL;
        end else begin
            start_q <= start;
        end
    end

    assign rise = start & ~start_q;
    assign trig = rise & ~busy;
    assign ovr  = rise & busy;

endmodule

// File: rtl/ab_seq_gen.sv
// Start-triggered A/B overlap sequence generator with done pulse and run counter.
// Optional embedded protocol assertions: define AB_SEQ_ASSERT_EN.
module ab_seq_gen
    import ab_seq_pkg::*;
#(
    parameter int A_LEN     = 2,
    parameter int B_DELAY   = 1,
    parameter int B_LEN     = 2,
    parameter int CNT_W     = 5,
    parameter int RUN_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 a,
    output logic                 b,
    output logic                 done,
    output logic                 busy,
    output logic                 overrun,
    output logic [RUN_CNT_W-1:0] run_cnt
);

    localparam int END_CNT = ab_end(A_LEN, B_DELAY, B_LEN);

    localparam logic [CNT_W-1:0] END_C = CNT_W'(END_CNT);
    localparam logic [CNT_W-1:0] A_HI  = CNT_W'(A_LEN);
    localparam logic [CNT_W-1:0] B_LO  = CNT_W'(B_DELAY + 1);
    localparam logic [CNT_W-1:0] B_HI  = CNT_W'(B_DELAY + B_LEN);

    if (A_LEN < 1 || A_LEN > 15) begin : g_bad_a_len
        $error("ab_seq_gen: A_LEN=%0d outside 1..15", A_LEN);
    end
    if (B_DELAY < 0 || B_DELAY > 15) begin : g_bad_b_delay
        $error("ab_seq_gen: B_DELAY=%0d outside 0..15", B_DELAY);
    end
    if (B_LEN < 1 || B_LEN > 15) begin : g_bad_b_len
        $error("ab_seq_gen: B_LEN=%0d outside 1..15", B_LEN);
    end
    if (CNT_W < 1 || CNT_W > 30 || (END_CNT + 1) > (1 << CNT_W)) begin : g_bad_cnt_w
        $error("ab_seq_gen: CNT_W=%0d cannot hold %0d", CNT_W, END_CNT + 1);
    end
    if (RUN_CNT_W < 1) begin : g_bad_run_cnt_w
        $error("ab_seq_gen: RUN_CNT_W must be at least 1");
    end

    function automatic logic dec_a(input logic [CNT_W-1:0] c);
        return (c >= CNT_W'(1)) && (c <= A_HI);
    endfunction

    function automatic logic dec_b(input logic [CNT_W-1:0] c);
        return (c >= B_LO) && (c <= B_HI);
    endfunction

    logic            trig;
    logic            ovr;
    ab_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    rise_det #(
        .RST_VAL (1'b1)
    ) u_rise_det (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .busy  (busy),
        .trig  (trig),
        .ovr   (ovr)
    );

    assign cnt_nxt = cnt + CNT_W'(1);

    // a/b are decoded from the count being loaded so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            a       <= 1'b0;
            b       <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
            overrun <= 1'b0;
            run_cnt <= '0;
        end else begin
            overrun <= ovr;
            done    <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (trig) begin
                        state <= RUN;
                        cnt   <= CNT_W'(1);
                        a     <= dec_a(CNT_W'(1));
                        b     <= dec_b(CNT_W'(1));
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    if (cnt == END_C) begin
                        state <= DONE;
                        cnt   <= '0;
                        a     <= 1'b0;
                        b     <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        if (run_cnt != '1) begin
                            run_cnt <= run_cnt + RUN_CNT_W'(1);
                        end
                    end else begin
                        cnt <= cnt_nxt;
                        a   <= dec_a(cnt_nxt);
                        b   <= dec_b(cnt_nxt);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef AB_SEQ_ASSERT_EN
    ap_a_run: assert property (@(posedge clk) disable iff (rst)
        ($rose(start) && !busy) |=> a [*A_LEN])
        $info("ap_a_run ok"); else $error("ap_a_run violated");

    ap_b_run: assert property (@(posedge clk) disable iff (rst)
        ($rose(start) && !busy) |=> ##B_DELAY b [*B_LEN])
        $info("ap_b_run ok"); else $error("ap_b_run violated");

    ap_done_at_end: assert property (@(posedge clk) disable iff (rst)
        ($rose(start) && !busy) |=> ##END_CNT done)
        $info("ap_done_at_end ok"); else $error("ap_done_at_end violated");

    ap_done_quiet: assert property (@(posedge clk) disable iff (rst)
        done |-> (!a && !b))
        $info("ap_done_quiet ok"); else $error("ap_done_quiet violated");

    ap_busy_done_excl: assert property (@(posedge clk) disable iff (rst)
        $onehot0({busy, done}))
        $info("ap_busy_done_excl ok"); else $error("ap_busy_done_excl violated");
`endif

endmodule

// File: tb/tb_ab_seq_gen.sv
// Randomized bench for ab_seq_gen: default instance plus a gapped (1,3,1) instance
// checked every cycle against an age-based behavioural model.
module tb_ab_seq_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       a_o     [2];
    logic       b_o     [2];
    logic       done_o  [2];
    logic       busy_o  [2];
    logic       ovr_o   [2];
    logic [7:0] rc_o    [2];

    int n_vec = 0;
    int n_err = 0;

    int AL [2] = '{2, 1};
    int BD [2] = '{1, 3};
    int BL [2] = '{2, 1};

    // Model: age = edges since the accepted trigger edge, -1 when no run is live.
    int age  [2];
    int runs [2];
    bit ovr_e[2];
    bit sq;

    always #5 clk = ~clk;

    ab_seq_gen u_def (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a_o[0]),
        .b       (b_o[0]),
        .done    (done_o[0]),
        .busy    (busy_o[0]),
        .overrun (ovr_o[0]),
        .run_cnt (rc_o[0])
    );

    ab_seq_gen #(
        .A_LEN   (1),
        .B_DELAY (3),
        .B_LEN   (1)
    ) u_gap (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a_o[1]),
        .b       (b_o[1]),
        .done    (done_o[1]),
        .busy    (busy_o[1]),
        .overrun (ovr_o[1]),
        .run_cnt (rc_o[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
        end
    endtask

    function automatic int end_of(input int i);
        return (AL[i] > BD[i] + BL[i]) ? AL[i] : BD[i] + BL[i];
    endfunction

    task automatic step(input bit r, input bit s);
        bit rise;
        rst   = r;
        start = s;
        @(posedge clk);
        rise = s & ~sq;
        sq   = r ? 1'b1 : s;
        for (int i = 0; i < 2; i++) begin
            int e;
            bit busy_prev;
            e = end_of(i);
            busy_prev = (age[i] >= 0) && (age[i] < e);
            if (r) begin
                age[i]   = -1;
                runs[i]  = 0;
                ovr_e[i] = 1'b0;
            end else begin
                ovr_e[i] = rise && busy_prev;
                if (rise && !busy_prev) begin
                    age[i] = 0;
                end else if (age[i] >= 0) begin
                    age[i]++;
                    if (age[i] > e) age[i] = -1;
                end
                if (age[i] == e && runs[i] < 255) runs[i]++;
            end
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            int e;
            e = end_of(i);
            chk($sformatf("a[%0d]", i),    32'(a_o[i]),
                32'(age[i] >= 0 && age[i] < AL[i]));
            chk($sformatf("b[%0d]", i),    32'(b_o[i]),
                32'(age[i] >= BD[i] && age[i] < BD[i] + BL[i]));
            chk($sformatf("done[%0d]", i), 32'(done_o[i]), 32'(age[i] == e));
            chk($sformatf("busy[%0d]", i), 32'(busy_o[i]), 32'(age[i] >= 0 && age[i] < e));
            chk($sformatf("ovr[%0d]", i),  32'(ovr_o[i]),  32'(ovr_e[i]));
            chk($sformatf("rcnt[%0d]", i), 32'(rc_o[i]),   32'(runs[i]));
        end
    endtask

    initial begin
        bit s;
        sq = 1'b1;
        for (int i = 0; i < 2; i++) begin
            age[i]   = -1;
            runs[i]  = 0;
            ovr_e[i] = 1'b0;
        end
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);

        // start held high through reset release: no run until a fresh rise
        repeat (3) step(1'b1, 1'b1);
        repeat (4) step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        repeat (5) step(1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b0);

        // second rise while busy
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        repeat (8) step(1'b0, 1'b0);

        // rise on the default instance's done cycle
        step(1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        repeat (8) step(1'b0, 1'b0);

        // reset in the middle of a run
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        repeat (6) step(1'b0, 1'b0);

        s = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 99) < 35) s = ~s;
            step($urandom_range(0, 149) == 0, s);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
